mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Sequences every MEM-stage load/store onto a single-port data-memory bus using a request/acknowledge handshake. It sits between the EX/MEM pipeline register outputs and the data memory, holds the pipeline with `stall` while an access is outstanding, and formats byte/half/word data per `funct3`. Misaligned or illegal accesses are trapped without touching the bus.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles waiting for `bus_ack`; used only when `MEM_TIMEOUT_EN` is defined.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; low clears all state immediately.
- `MemRead_mem` in 1: load request from EX/MEM.
- `MemWrite_mem` in 1: store request from EX/MEM.
- `funct3_mem` in 3: access size and sign.
- `alu_result_mem` in 32: byte address.
- `read_data2_mem` in 32: store data, right-aligned.
- `stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `load_data` out 32: aligned and extended load result.
- `load_valid` out 1: one-cycle pulse when `load_data` updates.
- `misaligned` out 1: one-cycle fault pulse.
- `timeout_err` out 1: one-cycle timeout pulse.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (bits [1:0]=0), `bus_wdata` out 32, `bus_be` out 4: registered bus request.
- `bus_ack` in 1, `bus_rdata` in 32: completion and read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - An access is present when `MemRead_mem | MemWrite_mem`.
  - If both are high, the access is a store.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Alignment rules: half requires `addr[0]=0`; word requires `addr[1:0]=0`.
  - Illegal `funct3` or a misaligned address: pulse `misaligned` next cycle, no bus activity, `stall` stays 0, FSM stays in IDLE.
  - Legal access: `stall` asserts combinationally this cycle. Latch address, `we`, byte enables and lane-replicated write data, then go to ACCESS.
- Byte enables:
  - Byte: `0001<<addr[1:0]`.
  - Half: `0011<<(2*addr[1])`.
  - Word: `1111`.
- Write data replication:
  - Byte: replicated to all four lanes.
  - Half: duplicated into both halves.
  - Word: passed through.
- ACCESS:
  - `bus_req=1`; all bus outputs stay stable; `stall=1`.
  - On `bus_ack=1`: capture `bus_rdata`, drop `bus_req` next cycle, go to DONE.
- DONE:
  - `stall=0`, so the pipeline advances on this edge.
  - For loads, `load_valid=1` and `load_data` updates. The selected lane is sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Always returns to IDLE. The held instruction is not re-issued.
- `load_data` holds its value until the next load completes.
- `bus_ack` is ignored in IDLE and DONE.

## Timing
- Reset (low) values: state IDLE; every output, including `load_data` and all `bus_*` outputs, is 0. Reset asserted mid-ACCESS drops `bus_req` immediately and abandons the access.
- Cycle 0: access arrives in IDLE, `stall=1`.
- Cycle 1: `bus_req=1`.
- Ack sampled in cycle k≥1, then DONE in cycle k+1.
- Stall is high for cycles 0..k, i.e. k+1 cycles. The minimum is 2 cycles (ack in cycle 1).
- Back-to-back accesses: the next instruction is evaluated in IDLE in cycle k+2. There is at most one outstanding request.
- `misaligned`, `load_valid` and `timeout_err` are single-cycle registered pulses.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches `TIMEOUT_CYCLES` without an ack: drop `bus_req`, pulse `timeout_err`, go to DONE.
  - A timed-out load returns `load_data=0` with `load_valid=1`.
  - An ack in the same cycle as the timeout wins (normal completion).
- `MEM_TIMEOUT_EN` not defined: ACCESS waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- LW, addr 0x100, ack in cycle 1, `bus_rdata`=0xDEADBEEF -> `bus_be`=1111, stall high 2 cycles, `load_data`=0xDEADBEEF with `load_valid` pulse.
- LB, addr 0x103, `bus_rdata`=0x80xxxxxx -> `bus_be`=1000, `load_data`=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH, addr 0x202, `read_data2_mem`=0x1234ABCD, ack after 5 cycles -> `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, bus outputs stable throughout, stall high 6 cycles.
- LW at 0x101, and `funct3`=011 -> `misaligned` pulse, `bus_req` never rises, `stall`=0.
- Reset driven low in the third ACCESS cycle -> `bus_req` and `stall` go to 0 asynchronously; after release, a new LW completes normally.
- With `MEM_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8, no ack -> `timeout_err` pulse after 8 ACCESS cycles, `load_data`=0, pipeline released.

Source files
------------

// File: rtl/mem_access_controller.sv
// mem_access_controller
// Sequences MEM-stage loads and stores onto a single-port data-memory bus
// using a req/ack handshake. It stalls the pipeline while an access is
// outstanding, places byte/half/word data on the correct lanes, and traps
// illegal or misaligned accesses without touching the bus.
//
// Optional feature: define MEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES cycles without bus_ack. A timed-out load completes with
// load_data = 0 and raises timeout_err. Without the macro, ACCESS waits
// indefinitely and timeout_err is tied to 0.
module mem_access_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemRead_mem,
    input  logic        MemWrite_mem,
    input  logic [2:0]  funct3_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] read_data2_mem,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // A zero timeout would complete every access before the bus could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Byte enables for an access of the given size (funct3[1:0]) and offset.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] off);
        case (size)
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = off[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Store data replicated onto every lane the access could use.
    function automatic logic [31:0] replicate_wdata(input logic [1:0]  size,
                                                    input logic [31:0] data);
        case (size)
            2'b00:   replicate_wdata = {4{data[7:0]}};
            2'b01:   replicate_wdata = {2{data[15:0]}};
            default: replicate_wdata = data;
        endcase
    endfunction

    // Pick the addressed lane out of the bus word and sign/zero extend it.
    // funct3[2] set means unsigned (LBU/LHU).
    function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3[1:0])
            2'b00:   format_load = f3[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   format_load = f3[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: format_load = rdata;
        endcase
    endfunction

    logic       access;
    logic       is_store;
    logic       legal_f3;
    logic       aligned;
    logic       start;
    logic       fault;
    logic       tmo_hit;
    logic [2:0] held_f3;
    logic [1:0] held_off;
    logic       held_load;

    assign access   = MemRead_mem | MemWrite_mem;
    assign is_store = MemWrite_mem;

    // Decode legality of funct3 for the access direction, and alignment.
    always_comb begin
        legal_f3 = 1'b0;
        aligned  = 1'b1;
        if (is_store) begin
            case (funct3_mem)
                3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
                default:                legal_f3 = 1'b0;
            endcase
        end else begin
            case (funct3_mem)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
                default:                                legal_f3 = 1'b0;
            endcase
        end
        case (funct3_mem[1:0])
            2'b01:   aligned = ~alu_result_mem[0];
            2'b10:   aligned = (alu_result_mem[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign start = (state == IDLE) && access && legal_f3 && aligned;
    assign fault = (state == IDLE) && access && !(legal_f3 && aligned);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and stall decode; stall is forced low while reset is held.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACCESS;
                    stall      = 1'b1;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ack || tmo_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Fires in the TIMEOUT_CYCLES-th ACCESS cycle unless an ack arrives.
    assign tmo_hit = (state == ACCESS) && !bus_ack &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // ACCESS cycle counter and timeout pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            if (start) begin
                tmo_cnt <= '0;
            end else if (state == ACCESS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Bus request registers, held access attributes, load result and pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            held_f3    <= '0;
            held_off   <= '0;
            held_load  <= 1'b0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= fault;
            load_valid <= 1'b0;
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= is_store;
                bus_addr  <= {alu_result_mem[31:2], 2'b00};
                bus_be    <= byte_enables(funct3_mem[1:0], alu_result_mem[1:0]);
                bus_wdata <= replicate_wdata(funct3_mem[1:0], read_data2_mem);
                held_f3   <= funct3_mem;
                held_off  <= alu_result_mem[1:0];
                held_load <= ~is_store;
            end else if ((state == ACCESS) && bus_ack) begin
                bus_req <= 1'b0;
                if (held_load) begin
                    load_data  <= format_load(bus_rdata, held_f3, held_off);
                    load_valid <= 1'b1;
                end
            end else if (tmo_hit) begin
                bus_req <= 1'b0;
                if (held_load) begin
                    load_data  <= '0;
                    load_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed testbench for mem_access_controller.
// Define MEM_TIMEOUT_EN for both files to include the timeout scenario.
module tb_mem_access_controller;

    logic        clock;
    logic        reset;
    logic        MemRead_mem;
    logic        MemWrite_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] read_data2_mem;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        timeout_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_controller #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .MemRead_mem   (MemRead_mem),
        .MemWrite_mem  (MemWrite_mem),
        .funct3_mem    (funct3_mem),
        .alu_result_mem(alu_result_mem),
        .read_data2_mem(read_data2_mem),
        .stall         (stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .misaligned    (misaligned),
        .timeout_err   (timeout_err),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_mem    = 1'b0;
        MemWrite_mem   = 1'b0;
        funct3_mem     = 3'b000;
        alu_result_mem = 32'h0;
        read_data2_mem = 32'h0;
        bus_ack        = 1'b0;
    endtask

    // One complete access with ack presented in ACCESS cycle ack_cyc.
    // exp_load is the value load_data must show from DONE onward.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int ack_cyc,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        int   stall_cnt;
        logic stable;
        MemRead_mem    = rd;
        MemWrite_mem   = wr;
        funct3_mem     = f3;
        alu_result_mem = addr;
        read_data2_mem = wd;
        bus_ack        = 1'b0;
        #1;
        check({tag, "_stall_c0"}, 32'(stall), 32'd1);
        check({tag, "_req_c0"}, 32'(bus_req), 32'd0);
        stall_cnt = stall ? 1 : 0;
        stable    = 1'b1;
        step();
        for (int cyc = 1; cyc <= ack_cyc; cyc++) begin
            if (stall) stall_cnt++;
            if (bus_req !== 1'b1 || bus_addr !== (addr & 32'hFFFF_FFFC) ||
                bus_we !== wr || bus_be !== exp_be || (wr && bus_wdata !== exp_wdata))
                stable = 1'b0;
            if (cyc == ack_cyc) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
            step();
            bus_ack   = 1'b0;
            bus_rdata = 32'h0BAD_F00D;
        end
        check({tag, "_bus_stable"}, 32'(stable), 32'd1);
        check({tag, "_stall_cycles"}, stall_cnt, ack_cyc + 1);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_req_done"}, 32'(bus_req), 32'd0);
        check({tag, "_valid_done"}, 32'(load_valid), 32'(!wr));
        check({tag, "_tmo_done"}, 32'(timeout_err), 32'd0);
        check({tag, "_load_data"}, load_data, exp_load);
        idle_inputs();
        step();
        check({tag, "_valid_after"}, 32'(load_valid), 32'd0);
        check({tag, "_load_hold"}, load_data, exp_load);
    endtask

    // An illegal or misaligned access: single misaligned pulse, no bus activity.
    task automatic do_fault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        MemRead_mem    = rd;
        MemWrite_mem   = wr;
        funct3_mem     = f3;
        alu_result_mem = addr;
        read_data2_mem = 32'h5555_AAAA;
        #1;
        check({tag, "_stall"}, 32'(stall), 32'd0);
        step();
        idle_inputs();
        #1;
        check({tag, "_pulse"}, 32'(misaligned), 32'd1);
        check({tag, "_req"}, 32'(bus_req), 32'd0);
        step();
        check({tag, "_pulse_end"}, 32'(misaligned), 32'd0);
        check({tag, "_req_after"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        bus_rdata = 32'h0;
        idle_inputs();
        step();
        check("rst_state_stall", 32'(stall), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Loads: word, byte signed/unsigned, half signed/unsigned.
        do_access("lw",  1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        do_access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h8012_3456, 4'b1000, 32'h0, 32'hFFFF_FF80);
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h8012_3456, 4'b1000, 32'h0, 32'h0000_0080);
        do_access("lh",  1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_access("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h1234_8001, 4'b0011, 32'h0, 32'h0000_8001);

        // Stores: load_data keeps the last load result.
        do_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0000_8001);
        do_access("sb_both", 1, 1, 3'b000, 32'h101, 32'h1122_335A, 3, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0000_8001);
        do_access("sw", 0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0000_8001);

        // Traps.
        do_fault("lw_mis",  1, 0, 3'b010, 32'h101);
        do_fault("ld_f011", 1, 0, 3'b011, 32'h100);
        do_fault("lh_mis",  1, 0, 3'b001, 32'h103);
        do_fault("sh_mis",  0, 1, 3'b001, 32'h201);
        do_fault("st_f100", 0, 1, 3'b100, 32'h100);

        // bus_ack while idle is ignored.
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        step();
        bus_ack = 1'b0;
        check("idle_ack_req", 32'(bus_req), 32'd0);
        check("idle_ack_valid", 32'(load_valid), 32'd0);
        check("idle_ack_data", load_data, 32'h0000_8001);

        // Reset asserted in the third ACCESS cycle.
        MemRead_mem    = 1'b1;
        funct3_mem     = 3'b010;
        alu_result_mem = 32'h100;
        step();
        step();
        step();
        check("rst_mid_req_before", 32'(bus_req), 32'd1);
        check("rst_mid_stall_before", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_load_data", load_data, 32'h0);
        check("rst_mid_be", 32'(bus_be), 32'h0);
        idle_inputs();
        step();
        reset = 1'b1;
        step();
        do_access("lw_after_rst", 1, 0, 3'b010, 32'h104, 32'h0, 2, 32'h1357_9BDF, 4'b1111, 32'h0, 32'h1357_9BDF);

`ifdef MEM_TIMEOUT_EN
        begin
            int tmo_stall;
            MemRead_mem    = 1'b1;
            funct3_mem     = 3'b010;
            alu_result_mem = 32'h108;
            #1;
            tmo_stall = stall ? 1 : 0;
            step();
            for (int cyc = 1; cyc <= 8; cyc++) begin
                if (stall) tmo_stall++;
                if (cyc == 8) begin
                    check("tmo_req_last", 32'(bus_req), 32'd1);
                    check("tmo_err_early", 32'(timeout_err), 32'd0);
                end
                step();
            end
            check("tmo_err", 32'(timeout_err), 32'd1);
            check("tmo_valid", 32'(load_valid), 32'd1);
            check("tmo_load_data", load_data, 32'h0);
            check("tmo_stall_done", 32'(stall), 32'd0);
            check("tmo_req_done", 32'(bus_req), 32'd0);
            check("tmo_stall_cycles", tmo_stall, 9);
            idle_inputs();
            step();
            check("tmo_err_end", 32'(timeout_err), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
